matmul_index_gen: RTL

- Parametrised successor of the single-index enable/clear counter: a three-level nested loop counter (i, j, k) for an M×N×K matrix multiply.
- Emits the current indices plus the flat row-major addresses of A[i][k], B[k][j] and C[i][j] on a valid/stall handshake.
- Marks the end of each dot product and of the whole job, and raises a done pulse.
- Sits between the controller FSM and the A/B memories and the C writeback logic.

---
 rtl/matmul_index_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/matmul_index_gen.sv
// Nested (i, j, k) loop counter for an M x N x K matrix multiply, emitting indices
// and the flat row-major addresses of A[i][k], B[k][j] and C[i][j] under a stall handshake.
module matmul_index_gen #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic [DW-1:0] dim_m_i,
  input  logic [DW-1:0] dim_n_i,
  input  logic [DW-1:0] dim_k_i,
  input  logic          stall_i,
  output logic          valid_o,
  output logic [DW-1:0] idx_i_o,
  output logic [DW-1:0] idx_j_o,
  output logic [DW-1:0] idx_k_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic [AW-1:0] addr_c_o,
  output logic          last_k_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [DW-1:0] DONE1 = DW'(1);
  localparam logic [AW-1:0] AONE  = AW'(1);

  state_e        state_q;
  logic [DW-1:0] dm_q, dn_q, dk_q;
  logic [DW-1:0] i_q, j_q, k_q;
  logic [AW-1:0] a_q, b_q, c_q, row_q;

  logic [DW-1:0] i_d, j_d, k_d;
  logic [AW-1:0] a_d, b_d, c_d, row_d;
  logic          k_end, j_end, i_end, job_end, dim_zero;

  assign k_end    = (k_q == dk_q - DONE1);
  assign j_end    = (j_q == dn_q - DONE1);
  assign i_end    = (i_q == dm_q - DONE1);
  assign job_end  = k_end & j_end & i_end;
  assign dim_zero = (dim_m_i == '0) | (dim_n_i == '0) | (dim_k_i == '0);

  // Incremental address stepping; row_q holds i*K so A rewinds without a multiply.
  always_comb begin
    i_d   = i_q;
    j_d   = j_q;
    k_d   = k_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    row_d = row_q;
    if (!k_end) begin
      k_d = k_q + DONE1;
      a_d = a_q + AONE;
      b_d = b_q + AW'(dn_q);
    end else if (!j_end) begin
      k_d = '0;
      j_d = j_q + DONE1;
      a_d = row_q;
      b_d = AW'(j_q) + AONE;
      c_d = c_q + AONE;
    end else begin
      k_d   = '0;
      j_d   = '0;
      i_d   = i_q + DONE1;
      row_d = row_q + AW'(dk_q);
      a_d   = row_d;
      b_d   = '0;
      c_d   = c_q + AONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dm_q    <= '0;
      dn_q    <= '0;
      dk_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
    end else if (clear_i) begin
      // Abort keeps the latched dims; only the walk position is discarded.
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dm_q    <= dim_m_i;
            dn_q    <= dim_n_i;
            dk_q    <= dim_k_i;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            row_q   <= '0;
            state_q <= dim_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!stall_i) begin
            if (job_end) begin
              state_q <= S_DONE;
            end else begin
              i_q   <= i_d;
              j_q   <= j_d;
              k_q   <= k_d;
              a_q   <= a_d;
              b_q   <= b_d;
              c_q   <= c_d;
              row_q <= row_d;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_o  = (state_q == S_RUN);
  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE);
  assign idx_i_o  = i_q;
  assign idx_j_o  = j_q;
  assign idx_k_o  = k_q;
  assign addr_a_o = a_q;
  assign addr_b_o = b_q;
  assign addr_c_o = c_q;
  assign last_k_o = valid_o & k_end;
  assign last_o   = valid_o & job_end;

endmodule
